// File: rtl/fp_cvt_int2fp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_cvt_int2fp : 32-bit signed/unsigned integer to IEEE-754 single (FCVT.S.W |
// |                 / FCVT.S.WU); iterative normaliser + registered rounding.   |
// | Optional: FP_CVT_FAST_NORM_EN enables 8-bit normalisation steps.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_cvt_int2fp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic             is_unsigned,
  input  logic [2:0]       rm,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             nx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] c_exp_top = 8'd158;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_mag, w_mag_nxt;
  logic [4:0]  r_sc, w_sc_nxt;
  logic        r_sign, w_sign_nxt;
  logic [2:0]  r_rm, w_rm_nxt;
  logic [31:0] r_s, w_s_nxt;
  logic        r_nx, w_nx_nxt;

  // Operand capture: magnitude of 0x80000000 negated stays 0x80000000.
  logic        w_sign_in;
  logic [31:0] w_mag_in;
  assign w_sign_in = A[31] & ~is_unsigned;
  assign w_mag_in  = w_sign_in ? (~A + 32'd1) : A;

  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic        w_g, w_st, w_nx, w_inc, w_carry;
  logic [22:0] w_man_inc;
  logic [7:0]  w_exp_rnd;

  assign w_exp = c_exp_top - {3'b000, r_sc};
  assign w_man = r_mag[30:8];
  assign w_g   = r_mag[7];
  assign w_st  = |r_mag[6:0];
  assign w_nx  = w_g | w_st;

  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      3'b001:  w_inc = 1'b0;
      3'b010:  w_inc = r_sign & w_nx;
      3'b011:  w_inc = ~r_sign & w_nx;
      3'b100:  w_inc = w_g;
      default: w_inc = w_g & (w_st | w_man[0]);
    endcase
  end

  // A carry out leaves the mantissa field at zero and bumps the exponent.
  assign {w_carry, w_man_inc} = {1'b0, w_man} + {23'd0, w_inc};
  assign w_exp_rnd            = w_exp + {7'd0, w_carry};

  always_comb begin
    w_state_nxt = r_state;
    w_mag_nxt   = r_mag;
    w_sc_nxt    = r_sc;
    w_sign_nxt  = r_sign;
    w_rm_nxt    = r_rm;
    w_s_nxt     = r_s;
    w_nx_nxt    = r_nx;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_sign_nxt = w_sign_in;
          w_mag_nxt  = w_mag_in;
          w_rm_nxt   = rm;
          w_sc_nxt   = 5'd0;
          if (w_mag_in == 32'd0) begin
            w_s_nxt     = 32'd0;
            w_nx_nxt    = 1'b0;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = NORM;
          end
        end
      end
      NORM: begin
        if (!r_mag[31]) begin
`ifdef FP_CVT_FAST_NORM_EN
          if (r_mag[31:24] == 8'h00) begin
            w_mag_nxt = {r_mag[23:0], 8'h00};
            w_sc_nxt  = r_sc + 5'd8;
          end else begin
            w_mag_nxt = {r_mag[30:0], 1'b0};
            w_sc_nxt  = r_sc + 5'd1;
          end
`else
          w_mag_nxt = {r_mag[30:0], 1'b0};
          w_sc_nxt  = r_sc + 5'd1;
`endif
        end else begin
          w_state_nxt = ROUND;
        end
      end
      ROUND: begin
        w_s_nxt     = {r_sign, w_exp_rnd, w_man_inc};
        w_nx_nxt    = w_nx;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mag   <= 32'd0;
      r_sc    <= 5'd0;
      r_sign  <= 1'b0;
      r_rm    <= 3'd0;
      r_s     <= 32'd0;
      r_nx    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mag   <= w_mag_nxt;
      r_sc    <= w_sc_nxt;
      r_sign  <= w_sign_nxt;
      r_rm    <= w_rm_nxt;
      r_s     <= w_s_nxt;
      r_nx    <= w_nx_nxt;
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign S    = r_s;
  assign nx   = r_nx;

endmodule
`default_nettype wire

// File: tb/tb_fp_cvt_int2fp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_cvt_int2fp : directed and random checks of fp_cvt_int2fp against an  |
// |                    exact-remainder rounding model.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fp_cvt_int2fp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = 32'd0;
  logic        is_unsigned = 1'b0;
  logic [2:0]  rm = 3'd0;
  wire         busy;
  wire         done;
  wire  [31:0] S;
  wire         nx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_cvt_int2fp #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .is_unsigned(is_unsigned),
    .rm(rm), .busy(busy), .done(done), .S(S), .nx(nx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: locate the leading one, then round on the exact discarded remainder.
  // lat = edges after the accepting edge until done is visible.
  task automatic model(input logic [31:0] a, input logic uns, input logic [2:0] m,
                       output logic [31:0] s, output logic x, output int lat);
    logic sg, inc;
    logic [31:0] mag;
    longint q, rem, half;
    int p, e, sh, lz, steps;
    sg  = a[31] & ~uns;
    mag = sg ? (32'd0 - a) : a;
    if (mag == 32'd0) begin
      s = 32'd0; x = 1'b0; lat = 0;
    end else begin
      p = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      e = 127 + p;
      if (p <= 23) begin
        q = longint'(mag) << (23 - p); rem = 0; half = 1;
      end else begin
        sh   = p - 23;
        q    = longint'(mag) >> sh;
        rem  = longint'(mag) & ((64'sd1 <<< sh) - 1);
        half = 64'sd1 <<< (sh - 1);
      end
      case (m)
        3'd1:    inc = 1'b0;
        3'd2:    inc = sg && (rem != 0);
        3'd3:    inc = !sg && (rem != 0);
        3'd4:    inc = (rem != 0) && (rem >= half);
        default: inc = (rem > half) || ((rem == half) && (q % 2 == 1));
      endcase
      q = q + longint'(inc);
      if (q == (64'sd1 <<< 24)) begin
        q = q >>> 1; e = e + 1;
      end
      s = {sg, 8'(e), 23'(q)};
      x = (rem != 0);
      lz = 31 - p;
      steps = 0;
`ifdef FP_CVT_FAST_NORM_EN
      while (lz > 0) begin
        if (lz >= 8) lz -= 8; else lz -= 1;
        steps++;
      end
`else
      steps = lz;
`endif
      lat = steps + 2;
    end
  endtask

  task automatic convert(input logic [31:0] a, input logic uns, input logic [2:0] m,
                         input bit noise, input string tag);
    logic [31:0] es;
    logic ex;
    int el, lat;
    model(a, uns, m, es, ex, el);
    @(posedge clk); #1;
    start = 1'b1; A = a; is_unsigned = uns; rm = m;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; is_unsigned = 1'($urandom); rm = 3'($urandom);
    lat = 0;
    while (!done && lat < 80) begin
      chk({tag, "/busy"}, {31'd0, busy}, 32'd1);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        A = $urandom; is_unsigned = 1'($urandom); rm = 3'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/done"}, {31'd0, done}, 32'd1);
    chk({tag, "/lat"}, lat, el);
    chk({tag, "/S"}, S, es);
    chk({tag, "/nx"}, {31'd0, nx}, {31'd0, ex});
    chk({tag, "/busy_done"}, {31'd0, busy}, 32'd1);
    start = noise; A = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "/pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "/idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "/S_held"}, S, es);
    chk({tag, "/nx_held"}, {31'd0, nx}, {31'd0, ex});
  endtask

  initial begin
    logic [31:0] ra;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/busy", {31'd0, busy}, 32'd0);
    chk("rst/done", {31'd0, done}, 32'd0);
    chk("rst/nx", {31'd0, nx}, 32'd0);
    chk("rst/S", S, 32'd0);
    rst_n = 1'b1;

    convert(32'h00000001, 1'b0, 3'd0, 1'b0, "one");
    convert(32'hFFFFFFFF, 1'b0, 3'd0, 1'b0, "m1_s");
    convert(32'hFFFFFFFF, 1'b1, 3'd0, 1'b0, "m1_u");
    convert(32'h80000000, 1'b0, 3'd0, 1'b0, "min_s");
    convert(32'h80000000, 1'b1, 3'd0, 1'b0, "min_u");
    convert(32'h01000001, 1'b0, 3'd0, 1'b0, "tie_rne");
    convert(32'h01000001, 1'b0, 3'd3, 1'b0, "tie_rup");
    convert(32'h01000001, 1'b0, 3'd1, 1'b0, "tie_rtz");
    convert(32'hFEFFFFFF, 1'b0, 3'd2, 1'b0, "neg_rdn");
    convert(32'h01000003, 1'b0, 3'd4, 1'b0, "rmm");
    convert(32'h01000003, 1'b0, 3'd6, 1'b0, "rm_rsvd");
    convert(32'h00000000, 1'b0, 3'd0, 1'b1, "zero");
    convert(32'h00012345, 1'b0, 3'd0, 1'b1, "noise");

    // Reset in the middle of normalisation aborts without a done pulse.
    @(posedge clk); #1;
    start = 1'b1; A = 32'h00000001; is_unsigned = 1'b0; rm = 3'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort/busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort/busy", {31'd0, busy}, 32'd0);
    chk("abort/done", {31'd0, done}, 32'd0);
    chk("abort/nx", {31'd0, nx}, 32'd0);
    chk("abort/S", S, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      chk("abort/no_done", {31'd0, done}, 32'd0);
    end
    convert(32'h12345678, 1'b0, 3'd0, 1'b0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = 32'd0 - ra;
      convert(ra, 1'($urandom), 3'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
